// File: rtl/cas_pkg.sv
// Shared types and TRS-80 Level II cassette timing for the tape player.
// Default cycle counts are derived from a 42 MHz clk_sys.
package cas_pkg;

    localparam int unsigned CAS_CLK_HZ       = 42_000_000;
    localparam int unsigned CAS_CELL_US      = 2000;  // 500 baud bit cell
    localparam int unsigned CAS_PULSE_US     = 125;
    localparam int unsigned CAS_CLK_PER_US   = CAS_CLK_HZ / 1_000_000;
    localparam int unsigned CAS_CELL_CYCLES  = CAS_CLK_PER_US * CAS_CELL_US;
    localparam int unsigned CAS_DATA_OFFSET  = CAS_CELL_CYCLES / 2;
    localparam int unsigned CAS_PULSE_CYCLES = CAS_CLK_PER_US * CAS_PULSE_US;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRIME = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } cas_state_e;

endpackage

// File: rtl/cas_bit_cell.sv
// One bit cell of the pulse train: cell counter plus clock/data pulse shaping.
// hold parks the counter and forces the output low while a byte is missing.
module cas_bit_cell
    import cas_pkg::*;
#(
    parameter int unsigned CELL_CYCLES  = CAS_CELL_CYCLES,
    parameter int unsigned DATA_OFFSET  = CAS_DATA_OFFSET,
    parameter int unsigned PULSE_CYCLES = CAS_PULSE_CYCLES
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic start_i,
    input  logic enable_i,
    input  logic hold_i,
    input  logic bit_i,
    output logic tape_out_o,
    output logic cell_end_o
);

    localparam int unsigned CW  = $clog2(CELL_CYCLES);
    localparam int unsigned CW1 = CW + 1;
    // One extra bit so a pulse window ending exactly at the cell edge still fits
    localparam logic [CW:0] LAST    = CW1'(CELL_CYCLES - 1);
    localparam logic [CW:0] PW_END  = CW1'(PULSE_CYCLES);
    localparam logic [CW:0] D_START = CW1'(DATA_OFFSET);
    localparam logic [CW:0] D_END   = CW1'(DATA_OFFSET + PULSE_CYCLES);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW:0]   cnt_x;
    logic          at_last;
    logic          clk_pulse;
    logic          data_pulse;

    assign cnt_x   = {1'b0, cnt_q};
    assign at_last = (cnt_x == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (start_i) begin
            cnt_d = '0;
        end else if (enable_i && !hold_i) begin
            cnt_d = at_last ? '0 : cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign clk_pulse  = (cnt_x < PW_END);
    assign data_pulse = bit_i && (cnt_x >= D_START) && (cnt_x < D_END);
    assign tape_out_o = !start_i && !hold_i && (clk_pulse || data_pulse);
    assign cell_end_o = !start_i && enable_i && !hold_i && at_last;

endmodule

// File: rtl/cas_tape_player.sv
// Replays a downloaded cassette image as a Level II 500-baud pulse train.
// One byte is shifted out while the next is prefetched into a holding buffer.
module cas_tape_player
    import cas_pkg::*;
#(
    parameter int unsigned CELL_CYCLES  = CAS_CELL_CYCLES,
    parameter int unsigned DATA_OFFSET  = CAS_DATA_OFFSET,
    parameter int unsigned PULSE_CYCLES = CAS_PULSE_CYCLES
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        play,
    input  logic        stop,
    input  logic        motor,
    input  logic [15:0] length,
    output logic        rd_req,
    output logic [15:0] rd_addr,
    input  logic [7:0]  rd_data,
    input  logic        rd_ack,
    output logic        tape_out,
    output logic        busy,
    output logic        done,
    output logic        underrun
);

    cas_state_e  state_q, state_d;
    logic [15:0] len_q, len_d;
    logic [15:0] addr_q, addr_d;
    logic        req_q, req_d;
    logic [7:0]  shreg_q, shreg_d;
    logic [7:0]  pbuf_q, pbuf_d;
    logic [2:0]  bidx_q, bidx_d;
    logic        pbuf_full_q, pbuf_full_d;
    logic        stall_q, stall_d;
    logic        underrun_q, underrun_d;

    logic        ack_ok;
    logic        more;
    logic [15:0] next_addr;
    logic        cell_idle;
    logic        cell_end;

    assign ack_ok    = rd_ack && req_q;
    assign more      = (addr_q != len_q - 16'd1);
    assign next_addr = addr_q + 16'd1;
    assign cell_idle = (state_q != ST_RUN);

    cas_bit_cell #(
        .CELL_CYCLES (CELL_CYCLES),
        .DATA_OFFSET (DATA_OFFSET),
        .PULSE_CYCLES(PULSE_CYCLES)
    ) u_cell (
        .clk_i     (clk_sys),
        .rst_i     (reset),
        .start_i   (cell_idle),
        .enable_i  (motor),
        .hold_i    (stall_q),
        .bit_i     (shreg_q[bidx_q]),
        .tape_out_o(tape_out),
        .cell_end_o(cell_end)
    );

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        addr_d      = addr_q;
        req_d       = req_q;
        shreg_d     = shreg_q;
        pbuf_d      = pbuf_q;
        bidx_d      = bidx_q;
        pbuf_full_d = pbuf_full_q;
        stall_d     = stall_q;
        underrun_d  = underrun_q;

        if (stop) begin
            state_d     = ST_IDLE;
            req_d       = 1'b0;
            pbuf_full_d = 1'b0;
            stall_d     = 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (play) begin
                        underrun_d  = 1'b0;
                        pbuf_full_d = 1'b0;
                        stall_d     = 1'b0;
                        if (length == '0) begin
                            state_d = ST_DONE;
                        end else begin
                            len_d   = length;
                            addr_d  = '0;
                            req_d   = 1'b1;
                            state_d = ST_PRIME;
                        end
                    end
                end
                ST_PRIME: begin
                    if (ack_ok) begin
                        shreg_d = rd_data;
                        bidx_d  = 3'd7;
                        req_d   = 1'b0;
                        state_d = ST_RUN;
                        if (more) begin
                            addr_d = next_addr;
                            req_d  = 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (ack_ok) begin
                        req_d = 1'b0;
                        if (stall_q) begin
                            shreg_d = rd_data;
                            bidx_d  = 3'd7;
                            stall_d = 1'b0;
                            if (more) begin
                                addr_d = next_addr;
                                req_d  = 1'b1;
                            end
                        end else begin
                            pbuf_d      = rd_data;
                            pbuf_full_d = 1'b1;
                        end
                    end
                    // An ack landing on the final cell edge goes straight to the shifter
                    if (cell_end) begin
                        if (bidx_q != 3'd0) begin
                            bidx_d = bidx_q - 3'd1;
                        end else if (pbuf_full_q || ack_ok) begin
                            shreg_d     = pbuf_full_q ? pbuf_q : rd_data;
                            bidx_d      = 3'd7;
                            pbuf_full_d = 1'b0;
                            if (more) begin
                                addr_d = next_addr;
                                req_d  = 1'b1;
                            end
                        end else if (req_q) begin
                            stall_d    = 1'b1;
                            underrun_d = 1'b1;
                        end else begin
                            state_d = ST_DONE;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            len_q       <= '0;
            addr_q      <= '0;
            req_q       <= 1'b0;
            shreg_q     <= '0;
            pbuf_q      <= '0;
            bidx_q      <= '0;
            pbuf_full_q <= 1'b0;
            stall_q     <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            addr_q      <= addr_d;
            req_q       <= req_d;
            shreg_q     <= shreg_d;
            pbuf_q      <= pbuf_d;
            bidx_q      <= bidx_d;
            pbuf_full_q <= pbuf_full_d;
            stall_q     <= stall_d;
            underrun_q  <= underrun_d;
        end
    end

    assign rd_req   = req_q;
    assign rd_addr  = addr_q;
    assign busy     = (state_q == ST_PRIME) || (state_q == ST_RUN);
    assign done     = (state_q == ST_DONE);
    assign underrun = underrun_q;

endmodule
